// File: rtl/edge_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_cfg_pkg : shared encodings for the edge-detector configuration loader
// Rev 1.0
// ---------------------------------------------------------------------------
package edge_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_ADDR = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_POLL_ADDR = 3'd3,
    ST_POLL_DATA = 3'd4,
    ST_POLL_WAIT = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAULT     = 3'd7
  } cfg_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam int CFG_IDX_WIDTH  = 0;
  localparam int CFG_IDX_HEIGHT = 1;
  localparam int CFG_IDX_RDADDR = 2;
  localparam int CFG_IDX_WRADDR = 3;
  localparam int CFG_IDX_FILTER = 4;

endpackage
`default_nettype wire

// File: rtl/ahb_rd_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_rd_port : single outstanding AHB-Lite read (address phase + data phase)
// Rev 1.0
// ---------------------------------------------------------------------------
module ahb_rd_port
  import edge_cfg_pkg::*;
#(
  parameter int BUSWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [BUSWIDTH-1:0] addr,
  output logic                accepted,
  output logic                done,
  output logic                err,
  output logic [BUSWIDTH-1:0] rdata,
  output logic [BUSWIDTH-1:0] haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  input  logic [BUSWIDTH-1:0] hrdata,
  input  logic                hready,
  input  logic [1:0]          hresp
);

  logic                bus_en;
  logic                busy;
  logic [BUSWIDTH-1:0] addr_q;
  logic                issue;

  // bus_en keeps the bus quiet for the first cycle out of reset, so reset
  // values on haddr/htrans hold while the controller already sits in LOAD_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_en <= 1'b0;
      busy   <= 1'b0;
      addr_q <= '0;
    end else begin
      bus_en <= 1'b1;
      if (accepted) begin
        busy   <= 1'b1;
        addr_q <= addr;
      end else if (done) begin
        busy   <= 1'b0;
      end
    end
  end

  assign issue    = req && bus_en && !busy;
  assign htrans   = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr    = issue ? addr : addr_q;
  assign hwrite   = 1'b0;
  assign accepted = issue && hready;
  assign done     = busy && hready;
  assign err      = done && (hresp == HRESP_ERROR);
  assign rdata    = hrdata;

endmodule
`default_nettype wire

// File: rtl/cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_loader : loads tagged config words over AHB-Lite, then polls kickstart
// Rev 1.0
// ---------------------------------------------------------------------------
module cfg_loader
  import edge_cfg_pkg::*;
#(
  parameter int                     BUSWIDTH  = 32,
  parameter int                     NUM_REGS  = CFG_IDX_FILTER + 1,
  parameter int                     TAG_W     = 3,
  parameter logic [BUSWIDTH-1:0]    CFG_BASE  = 'hD00,
  parameter int                     MAX_RETRY = 3,
  parameter int                     POLL_GAP  = 8
) (
  input  logic                               ahb_hclk,
  input  logic                               n_rst,
  input  logic                               start,
  output logic [BUSWIDTH-1:0]                ahb_haddr,
  output logic [1:0]                         ahb_htrans,
  output logic                               ahb_hwrite,
  input  logic [BUSWIDTH-1:0]                ahb_hrdata,
  input  logic                               ahb_hready,
  input  logic [1:0]                         ahb_hresp,
  output logic [NUM_REGS*(BUSWIDTH-TAG_W)-1:0] cfg_word,
  output logic                               cfg_valid,
  output logic                               final_enable,
  output logic                               fault,
  output logic [$clog2(NUM_REGS+1)-1:0]      fault_idx
);

  localparam int PAY_W   = BUSWIDTH - TAG_W;
  localparam int IDX_W   = $clog2(NUM_REGS + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W   = $clog2(POLL_GAP + 1);
  localparam logic [BUSWIDTH-1:0] KICK_ADDR = CFG_BASE + BUSWIDTH'(4 * NUM_REGS);

  cfg_state_t                  state, state_d;
  logic [IDX_W-1:0]            idx, idx_d, fault_idx_d;
  logic [RETRY_W-1:0]          retry, retry_d;
  logic [GAP_W-1:0]            gap, gap_d;
  logic [NUM_REGS*PAY_W-1:0]   cfg_word_d;
  logic                        cfg_valid_d, final_enable_d, fault_d;
  logic                        rd_req, rd_accepted, rd_done, rd_err;
  logic [BUSWIDTH-1:0]         rd_addr, rd_data;
  logic [TAG_W-1:0]            tag_exp;
  logic                        retry_left;

  ahb_rd_port #(
    .BUSWIDTH (BUSWIDTH)
  ) u_rd_port (
    .clk      (ahb_hclk),
    .rst_n    (n_rst),
    .req      (rd_req),
    .addr     (rd_addr),
    .accepted (rd_accepted),
    .done     (rd_done),
    .err      (rd_err),
    .rdata    (rd_data),
    .haddr    (ahb_haddr),
    .htrans   (ahb_htrans),
    .hwrite   (ahb_hwrite),
    .hrdata   (ahb_hrdata),
    .hready   (ahb_hready),
    .hresp    (ahb_hresp)
  );

  assign rd_req     = (state == ST_LOAD_ADDR) || (state == ST_POLL_ADDR);
  assign rd_addr    = (state == ST_POLL_ADDR) ? KICK_ADDR
                    : CFG_BASE + {{(BUSWIDTH-IDX_W-2){1'b0}}, idx, 2'b00};
  assign tag_exp    = TAG_W'(idx) + TAG_W'(1);
  assign retry_left = (retry < RETRY_W'(MAX_RETRY));

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) state <= ST_LOAD_ADDR;
    else        state <= state_d;
  end

  always_comb begin
    state_d        = state;
    idx_d          = idx;
    retry_d        = retry;
    gap_d          = gap;
    cfg_word_d     = cfg_word;
    cfg_valid_d    = cfg_valid;
    final_enable_d = final_enable;
    fault_d        = fault;
    fault_idx_d    = fault_idx;
    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          state_d        = ST_LOAD_ADDR;
          idx_d          = '0;
          retry_d        = '0;
          cfg_valid_d    = 1'b0;
          final_enable_d = 1'b0;
          fault_d        = 1'b0;
          fault_idx_d    = '0;
        end
      end
      ST_LOAD_ADDR: if (rd_accepted) state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        if (rd_done) begin
          if (rd_err) begin
            if (retry_left) begin
              retry_d = retry + 1'b1;
              state_d = ST_LOAD_ADDR;
            end else begin
              state_d     = ST_FAULT;
              fault_d     = 1'b1;
              fault_idx_d = idx;
              cfg_valid_d = 1'b0;
            end
          end else if (rd_data[BUSWIDTH-1 -: TAG_W] == tag_exp) begin
            cfg_word_d[idx*PAY_W +: PAY_W] = rd_data[PAY_W-1:0];
            retry_d = '0;
            if (idx == IDX_W'(NUM_REGS - 1)) begin
              cfg_valid_d = 1'b1;
              state_d     = ST_POLL_ADDR;
            end else begin
              idx_d   = idx + 1'b1;
              state_d = ST_LOAD_ADDR;
            end
          end else begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            fault_idx_d = idx;
            cfg_valid_d = 1'b0;
          end
        end
      end
      ST_POLL_ADDR: if (rd_accepted) state_d = ST_POLL_DATA;
      ST_POLL_DATA: begin
        if (rd_done) begin
          if (rd_err) begin
            if (retry_left) begin
              retry_d = retry + 1'b1;
              state_d = ST_POLL_ADDR;
            end else begin
              state_d     = ST_FAULT;
              fault_d     = 1'b1;
              fault_idx_d = IDX_W'(NUM_REGS);
              cfg_valid_d = 1'b0;
            end
          end else begin
            retry_d = '0;
            if (rd_data[0]) begin
              state_d        = ST_DONE;
              final_enable_d = 1'b1;
            end else begin
              state_d = ST_POLL_WAIT;
              gap_d   = GAP_W'(POLL_GAP - 1);
            end
          end
        end
      end
      ST_POLL_WAIT: begin
        if (gap == '0) state_d = ST_POLL_ADDR;
        else           gap_d   = gap - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      idx          <= '0;
      retry        <= '0;
      gap          <= '0;
      cfg_word     <= '0;
      cfg_valid    <= 1'b0;
      final_enable <= 1'b0;
      fault        <= 1'b0;
      fault_idx    <= '0;
    end else begin
      idx          <= idx_d;
      retry        <= retry_d;
      gap          <= gap_d;
      cfg_word     <= cfg_word_d;
      cfg_valid    <= cfg_valid_d;
      final_enable <= final_enable_d;
      fault        <= fault_d;
      fault_idx    <= fault_idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cfg_loader : directed vectors against a small behavioural AHB slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cfg_loader;

  localparam int PW = 29;

  typedef struct packed {
    logic [4:0][31:0] words;
    logic [3:0]       err_word;
    logic [3:0]       err_cnt;
    logic [3:0]       kick_zeros;
    logic [3:0]       stall;
    logic             exp_fault;
    logic [2:0]       exp_fidx;
    logic [7:0]       exp_txn;
    logic [4:0][28:0] exp_pl;
  } vec_t;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [31:0]     hrdata = '0;
  logic            hready = 1'b1;
  logic [1:0]      hresp = 2'b00;
  logic [5*PW-1:0] cfg_word;
  logic            cfg_valid, final_enable, fault;
  logic [2:0]      fault_idx;

  cfg_loader dut (
    .ahb_hclk     (clk),
    .n_rst        (n_rst),
    .start        (start),
    .ahb_haddr    (haddr),
    .ahb_htrans   (htrans),
    .ahb_hwrite   (hwrite),
    .ahb_hrdata   (hrdata),
    .ahb_hready   (hready),
    .ahb_hresp    (hresp),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .final_enable (final_enable),
    .fault        (fault),
    .fault_idx    (fault_idx)
  );

  always #5 clk = ~clk;

  // slave configuration, written by the test sequence
  logic [31:0] mem [0:4];
  int cfg_err_word = 0, cfg_err_cnt = 0, cfg_kick_zeros = 0, cfg_stall = 0;

  // slave / monitor state
  int          edge_cnt = 0;
  logic        dp_active = 1'b0;
  logic [31:0] dp_addr = '0;
  int          stall_left = 0, err_seen = 0, kick_seen = 0;
  logic [1:0]  s_htrans = 2'b00;
  logic [31:0] s_haddr = '0;
  logic        s_hready = 1'b1;
  logic [31:0] acc_addr [$];
  int          acc_edge [$];
  int          valid_edge = 0, fe_edge = 0, stall_viol = 0;
  logic        prev_valid = 1'b0, prev_fe = 1'b0;

  int n_pass = 0, n_total = 0;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    s_htrans = htrans;
    s_haddr  = haddr;
    s_hready = hready;
    if (dp_active && !hready && (htrans != 2'b00 || haddr != dp_addr)) stall_viol++;
    if (cfg_valid && !prev_valid) valid_edge = edge_cnt;
    if (final_enable && !prev_fe) fe_edge = edge_cnt;
    prev_valid = cfg_valid;
    prev_fe    = final_enable;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_active = 1'b0; stall_left = 0; err_seen = 0; kick_seen = 0;
      hready = 1'b1; hresp = 2'b00; hrdata = '0;
    end else begin
      #1;
      if (n_rst) begin
        if (dp_active && s_hready) dp_active = 1'b0;
        if (s_htrans == 2'b10 && s_hready) begin
          dp_active  = 1'b1;
          dp_addr    = s_haddr;
          stall_left = cfg_stall;
          acc_addr.push_back(s_haddr);
          acc_edge.push_back(edge_cnt);
        end
        hready = 1'b1; hresp = 2'b00; hrdata = '0;
        if (dp_active) begin
          if (stall_left > 0) begin
            hready = 1'b0;
            stall_left--;
          end else begin
            int w;
            w = int'((dp_addr - 32'hD00) >> 2);
            if (w == cfg_err_word && err_seen < cfg_err_cnt) begin
              hresp = 2'b01;
              err_seen++;
            end else if (w < 5) begin
              hrdata = mem[w];
            end else if (w == 5) begin
              hrdata = (kick_seen < cfg_kick_zeros) ? 32'h0 : 32'h1;
              kick_seen++;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [4:0][31:0] w, input int ew, input int ec,
                               input int kz, input int st, input logic ef, input int fi,
                               input int tx, input logic [4:0][28:0] pl);
    vec_t v;
    v.words = w; v.err_word = 4'(ew); v.err_cnt = 4'(ec); v.kick_zeros = 4'(kz);
    v.stall = 4'(st); v.exp_fault = ef; v.exp_fidx = 3'(fi); v.exp_txn = 8'(tx);
    v.exp_pl = pl;
    return v;
  endfunction

  task automatic set_cfg(input vec_t v);
    for (int i = 0; i < 5; i++) mem[i] = v.words[i];
    cfg_err_word = int'(v.err_word); cfg_err_cnt = int'(v.err_cnt);
    cfg_kick_zeros = int'(v.kick_zeros); cfg_stall = int'(v.stall);
  endtask

  task automatic wait_end(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (fault || final_enable) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, " timeout"}, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, output int base);
    n_rst = 1'b0; start = 1'b0;
    set_cfg(v);
    repeat (2) @(negedge clk);
    base = acc_addr.size();
    n_rst = 1'b1;
    wait_end("run");
  endtask

  vec_t vecs [9];
  vec_t vk, vr;
  logic [4:0][31:0] wn;
  logic [4:0][28:0] pn;
  int base, first, got;

  initial begin
    wn = {32'hA0000001, 32'h8000157C, 32'h600001F4, 32'h40000151, 32'h20000151};
    pn = {29'h1, 29'h157C, 29'h1F4, 29'h151, 29'h151};
    vecs[0] = mkv(wn, 0, 0, 0, 0, 1'b0, 0, 6, pn);
    vecs[1] = mkv({32'hA0000001, 32'h8000157C, 32'h400001F4, 32'h40000151, 32'h20000151},
                  0, 0, 0, 0, 1'b1, 2, 3, {29'h0, 29'h0, 29'h0, 29'h151, 29'h151});
    vecs[2] = mkv(wn, 1, 3, 0, 0, 1'b0, 0, 9, pn);
    vecs[3] = mkv(wn, 1, 4, 0, 0, 1'b1, 1, 5, {29'h0, 29'h0, 29'h0, 29'h0, 29'h151});
    vecs[4] = mkv(wn, 0, 0, 0, 4, 1'b0, 0, 6, pn);
    vecs[5] = mkv({32'hBFFFFFFF, 32'h80000000, 32'h60ABCDEF, 32'h5FFFFFFF, 32'h20000000},
                  0, 0, 1, 0, 1'b0, 0, 7,
                  {29'h1FFFFFFF, 29'h0, 29'h0ABCDEF, 29'h1FFFFFFF, 29'h0});
    vecs[6] = mkv(wn, 5, 4, 0, 0, 1'b1, 5, 9, pn);
    vecs[7] = mkv({32'hA0000001, 32'h8000157C, 32'h600001F4, 32'h40000151, 32'h00000151},
                  0, 0, 0, 0, 1'b1, 0, 1, '0);
    vecs[8] = mkv({32'hC0000001, 32'h8000157C, 32'h600001F4, 32'h40000151, 32'h20000151},
                  0, 0, 0, 0, 1'b1, 4, 5, {29'h0, 29'h157C, 29'h1F4, 29'h151, 29'h151});

    #1;
    chk("reset outputs", {cfg_valid, final_enable, fault, fault_idx, htrans, haddr, hwrite}, '0);
    chk("reset cfg_word", cfg_word, '0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], base);
      chk($sformatf("v%0d fault", i), fault, vecs[i].exp_fault);
      chk($sformatf("v%0d fault_idx", i), fault_idx, vecs[i].exp_fidx);
      chk($sformatf("v%0d cfg_valid", i), cfg_valid, !vecs[i].exp_fault);
      chk($sformatf("v%0d final_enable", i), final_enable, !vecs[i].exp_fault);
      chk($sformatf("v%0d cfg_word", i), cfg_word, vecs[i].exp_pl);
      chk($sformatf("v%0d htrans idle", i), htrans, 2'b00);
      chk($sformatf("v%0d transfers", i), acc_addr.size() - base, vecs[i].exp_txn);
    end

    // nominal load: latency and address sequence
    run_vec(vecs[0], base);
    first = (acc_edge.size() > base) ? acc_edge[base] : -100;
    chk("h1 cfg_valid latency", valid_edge - first, 9);
    chk("h1 final_enable after poll", fe_edge - valid_edge, 2);
    for (int i = 0; i < 6; i++)
      chk($sformatf("h1 haddr %0d", i), (acc_addr.size() > base + i) ? acc_addr[base+i] : 32'hX,
          32'hD00 + 32'(4 * i));

    // kickstart reads 0, 0, 1
    vk = vecs[0]; vk.kick_zeros = 4'd2; vk.exp_txn = 8'd8;
    run_vec(vk, base);
    chk("h2 transfers", acc_addr.size() - base, 8);
    if (acc_addr.size() >= base + 8) begin
      for (int i = 5; i < 8; i++) chk($sformatf("h2 poll addr %0d", i), acc_addr[base+i], 32'hD14);
      chk("h2 poll gap 1", acc_edge[base+6] - acc_edge[base+5], 10);
      chk("h2 poll gap 2", acc_edge[base+7] - acc_edge[base+6], 10);
      chk("h2 final_enable timing", fe_edge - acc_edge[base+7], 1);
    end

    // four wait states in every data phase
    got = stall_viol;
    run_vec(vecs[4], base);
    first = (acc_edge.size() > base) ? acc_edge[base] : -100;
    chk("h3 bus stable while stalled", stall_viol - got, 0);
    chk("h3 cfg_valid latency", valid_edge - first, 29);
    chk("h3 final_enable after poll", fe_edge - valid_edge, 6);

    // asynchronous reset while word 3 is in flight
    n_rst = 1'b0; set_cfg(vecs[0]);
    repeat (2) @(negedge clk);
    base = acc_addr.size(); n_rst = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_addr.size() - base >= 4) begin got = 1; break; end
    end
    chk("h4 reached word3", got, 1);
    chk("h4 partial load", cfg_word, {29'h0, 29'h0, 29'h1F4, 29'h151, 29'h151});
    #2 n_rst = 1'b0;
    #1;
    chk("h4 outputs in reset", {cfg_valid, final_enable, fault, fault_idx, htrans, haddr, hwrite}, '0);
    chk("h4 cfg_word in reset", cfg_word, '0);
    @(negedge clk); @(negedge clk);
    base = acc_addr.size(); n_rst = 1'b1;
    wait_end("h4");
    chk("h4 restart addr", (acc_addr.size() > base) ? acc_addr[base] : 32'hX, 32'hD00);
    chk("h4 reload payloads", cfg_word, pn);

    // start from DONE reloads; a second start mid-load is ignored
    vr = mkv({32'hA000000E, 32'h8000000D, 32'h6000000C, 32'h4000000B, 32'h2000000A},
             0, 0, 0, 0, 1'b0, 0, 6, {29'hE, 29'hD, 29'hC, 29'hB, 29'hA});
    set_cfg(vr);
    base = acc_addr.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("h5 start clears flags", {cfg_valid, final_enable}, 2'b00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_addr.size() - base >= 2) break;
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_end("h5");
    chk("h5 new payloads", cfg_word, vr.exp_pl);
    chk("h5 transfers", acc_addr.size() - base, 6);
    chk("h5 first addr", (acc_addr.size() > base) ? acc_addr[base] : 32'hX, 32'hD00);
    chk("h5 done flags", {cfg_valid, final_enable, fault}, 3'b110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
